// File: rtl/data_pad_feeder_pkg.sv
// Shared definitions for the PE-side feeder blocks: default widths,
// controller state encoding and the padded-size helper.
package data_pad_feeder_pkg;

   localparam int dwidth_def = 16;
   localparam int awidth_def = 10;

   // Row/column positions and frame sizes fit in 5 bits (M <= 31).
   localparam int pos_w = 5;
   typedef logic [pos_w-1:0] pos_t;

   // Largest padded frame edge the scan counters can represent.
   localparam int max_padded = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Padded edge M = N + 2*pad, one bit wider so oversize requests are visible.
   function automatic logic [pos_w:0] padded_size(input pos_t n, input int unsigned p);
      return {1'b0, n} + (pos_w+1)'(2 * p);
   endfunction

endpackage

// File: rtl/data_pad_feeder_pad_scan_counter.sv
// Raster scan over the padded frame: row/column counters, interior
// detection and the buffer address counter (one increment per interior
// position, so interior addresses come out in raster order without a multiply).
module pad_scan_counter
   import data_pad_feeder_pkg::*;
#(
   parameter int          awidth = awidth_def,
   parameter int unsigned pad    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              step,
   input  pos_t              size_n,
   input  pos_t              size_m,
   output logic              interior,
   output logic              last,
   output logic [awidth-1:0] addr
);

   pos_t       row;
   pos_t       col;
   logic [5:0] row_x;
   logic [5:0] col_x;
   logic [5:0] lo;
   logic [5:0] hi;
   logic       col_wrap;

   // Classify the current position and detect the end of a row and of the frame.
   always_comb begin
      row_x    = {1'b0, row};
      col_x    = {1'b0, col};
      lo       = 6'(pad);
      hi       = {1'b0, size_n} + 6'(pad);
      interior = (row_x >= lo) && (row_x < hi) && (col_x >= lo) && (col_x < hi);
      col_wrap = (col == size_m - 5'd1);
      last     = col_wrap && (row == size_m - 5'd1);
   end

   // Advance one position per issued cycle; the address only moves on interior positions.
   // NOTE: reset is sampled on the clock edge like any other input, so it sits inside always_ff.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         row  <= '0;
         col  <= '0;
         addr <= '0;
      end else if (step) begin
         if (col_wrap) begin
            col <= '0;
            row <= row + 5'd1;
         end else begin
            col <= col + 5'd1;
         end
         if (interior) begin
            addr <= addr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/data_pad_feeder.sv
// Streams a zero-padded feature map to a PE: reads the unpadded map from
// a buffer in raster order and inserts a pad-wide zero border around it.
module data_pad_feeder
   import data_pad_feeder_pkg::*;
#(
   parameter int          dwidth = dwidth_def,
   parameter int          awidth = awidth_def,
   parameter int unsigned pad    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [4:0]               featmap_size,
   output logic                     mem_rd_en,
   output logic [awidth-1:0]        mem_addr,
   input  logic signed [dwidth-1:0] mem_rd_data,
   output logic signed [dwidth-1:0] dout,
   output logic                     dout_en,
   output logic                     dout_last,
   output logic                     busy,
   output logic                     done
);

   state_t            state;
   logic              flush_cnt;
   pos_t              m_q;
   pos_t              n_q;
   logic              issued_last;
   logic [pos_w:0]    m_req;
   logic              accept;
   logic              issue;
   logic              scan_clear;
   pos_t              n_sel;
   pos_t              m_sel;
   logic              scan_interior;
   logic              scan_last;
   logic [awidth-1:0] scan_addr;

   // Issue-stage tags travelling alongside the buffer read.
   logic              vld0;
   logic              last0;
   logic              vld1;
   logic              int1;
   logic              last1;

   // Start acceptance and scan control; the first position is issued on the accepting edge.
   always_comb begin
      m_req      = padded_size(featmap_size, pad);
      // An empty padded frame has nothing to emit, so it is not started.
      accept     = (state == IDLE) && start && (m_req <= (pos_w+1)'(max_padded)) && (m_req != '0);
      issue      = accept || ((state == RUN) && !issued_last);
      scan_clear = (state != RUN) && !accept;
      n_sel      = (state == IDLE) ? featmap_size : n_q;
      m_sel      = (state == IDLE) ? m_req[pos_w-1:0] : m_q;
   end

   pad_scan_counter #(
      .awidth (awidth),
      .pad    (pad)
   ) u_scan (
      .clk      (clk),
      .rst      (rst),
      .clear    (scan_clear),
      .step     (issue),
      .size_n   (n_sel),
      .size_m   (m_sel),
      .interior (scan_interior),
      .last     (scan_last),
      .addr     (scan_addr)
   );

   // Frame controller with registered read strobe, address, busy and done.
   // NOTE: state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         flush_cnt   <= 1'b0;
         m_q         <= '0;
         n_q         <= '0;
         issued_last <= 1'b0;
         vld0        <= 1'b0;
         last0       <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  n_q   <= featmap_size;
                  m_q   <= m_req[pos_w-1:0];
               end
            end
            RUN: begin
               if (issued_last) begin
                  state     <= FLUSH;
                  flush_cnt <= 1'b0;
               end
            end
            FLUSH: begin
               // Two cycles let the last read drain through the output pipeline.
               if (flush_cnt) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  flush_cnt <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         vld0 <= issue;
         if (issue) begin
            mem_rd_en   <= scan_interior;
            last0       <= scan_last;
            issued_last <= scan_last;
            // Border positions leave the address where it was.
            if (scan_interior) begin
               mem_addr <= scan_addr;
            end
         end else begin
            mem_rd_en <= 1'b0;
            last0     <= 1'b0;
         end
      end
   end

   // Output pipeline: align tags with read data, substitute zeros on the border.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld1      <= 1'b0;
         int1      <= 1'b0;
         last1     <= 1'b0;
         dout_en   <= 1'b0;
         dout_last <= 1'b0;
         dout      <= '0;
      end else begin
         vld1      <= vld0;
         int1      <= mem_rd_en;
         last1     <= last0;
         dout_en   <= vld1;
         dout_last <= last1;
         dout      <= int1 ? mem_rd_data : '0;
      end
   end

endmodule

// File: tb/tb_data_pad_feeder.sv
// Self-checking bench for data_pad_feeder: table-driven frames, hand-written
// abort/back-to-back sequences and random sizes, compared against a
// padded-raster model computed directly from N, pad and the buffer contents.
module tb_data_pad_feeder;
   localparam int dwidth = 16;
   localparam int awidth = 10;
   localparam int pad_p  = 1;

   logic                     clk;
   logic                     rst;
   logic                     start;
   logic [4:0]               featmap_size;
   logic                     mem_rd_en;
   logic [awidth-1:0]        mem_addr;
   logic signed [dwidth-1:0] mem_rd_data;
   logic signed [dwidth-1:0] dout;
   logic                     dout_en;
   logic                     dout_last;
   logic                     busy;
   logic                     done;

   logic signed [dwidth-1:0] mem [0:(1<<awidth)-1];

   int total = 0;
   int bad   = 0;

   data_pad_feeder #(
      .dwidth (dwidth),
      .awidth (awidth),
      .pad    (pad_p)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .featmap_size (featmap_size),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_rd_data  (mem_rd_data),
      .dout         (dout),
      .dout_en      (dout_en),
      .dout_last    (dout_last),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer with one cycle of read latency.
   initial mem_rd_data = '0;
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " dout"}, longint'(dout), 0);
      check({tag, " dout_en"}, longint'(dout_en), 0);
      check({tag, " dout_last"}, longint'(dout_last), 0);
      check({tag, " done"}, longint'(done), 0);
      check({tag, " busy"}, longint'(busy), 0);
      check({tag, " mem_rd_en"}, longint'(mem_rd_en), 0);
      check({tag, " mem_addr"}, longint'(mem_addr), 0);
   endtask

   // Runs one frame. k counts falling edges after the edge that samples start.
   task automatic run_frame(input int n, input int mid_k, input bit ramp, input int exp_outs,
                            input int exp_reads, input bit exp_acc, input bit pre_started,
                            input int chain_n, input string tag);
      int m, t, limit;
      int first_k, last_k, n_last, done_k, n_done, busy_bad, gaps, data_bad, read_bad;
      bit prev_en;
      logic signed [dwidth-1:0] got[$];
      logic signed [dwidth-1:0] exp_q[$];
      int reads[$];

      m = n + 2 * pad_p;
      t = exp_acc ? m * m : 0;
      for (int i = 0; i < n * n; i++) mem[i] = ramp ? 16'(i + 1) : 16'($urandom);

      // Reference: padded raster, interior pixels taken from the buffer.
      if (exp_acc) begin
         for (int r = 0; r < m; r++) begin
            for (int c = 0; c < m; c++) begin
               if (r >= pad_p && r < n + pad_p && c >= pad_p && c < n + pad_p)
                  exp_q.push_back(mem[(r - pad_p) * n + (c - pad_p)]);
               else
                  exp_q.push_back('0);
            end
         end
      end

      if (!pre_started) begin
         @(negedge clk);
         featmap_size = 5'(n);
         start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;

      first_k = -1; last_k = -1; done_k = -1;
      n_last = 0; n_done = 0; busy_bad = 0; gaps = 0; prev_en = 1'b0;
      limit = t + 6;
      for (int k = 0; k <= limit; k++) begin
         if (dout_en) begin
            if (first_k < 0) first_k = k;
            else if (!prev_en) gaps++;
            got.push_back(dout);
         end
         prev_en = dout_en;
         if (dout_last) begin n_last++; last_k = k; end
         if (done) begin n_done++; done_k = k; end
         if (mem_rd_en) reads.push_back(int'(mem_addr));
         if (busy != (exp_acc && k <= t + 1)) busy_bad++;
         if (k == mid_k) start = 1'b1;
         else if (k == mid_k + 1) start = 1'b0;
         if (chain_n >= 0 && k == t + 2) begin
            featmap_size = 5'(chain_n);
            start = 1'b1;
            break;
         end
         @(negedge clk);
      end

      data_bad = 0;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i] !== exp_q[i]) data_bad++;
      read_bad = 0;
      for (int i = 0; i < reads.size(); i++)
         if (reads[i] != i) read_bad++;

      check({tag, " output_count"}, got.size(), exp_outs);
      check({tag, " data_errors"}, data_bad, 0);
      check({tag, " read_count"}, reads.size(), exp_reads);
      check({tag, " read_order_errors"}, read_bad, 0);
      check({tag, " dout_en_gaps"}, gaps, 0);
      check({tag, " busy_errors"}, busy_bad, 0);
      check({tag, " done_pulses"}, n_done, exp_acc ? 1 : 0);
      check({tag, " last_pulses"}, n_last, exp_acc ? 1 : 0);
      if (exp_acc) begin
         check({tag, " first_dout_en_cycle"}, first_k, 2);
         check({tag, " dout_last_cycle"}, last_k, t + 1);
         check({tag, " done_cycle"}, done_k, t + 2);
      end
   endtask

   // Abort an N=3 frame on its 10th output, then confirm a clean restart.
   task automatic reset_mid_frame();
      int seen;
      for (int i = 0; i < 9; i++) mem[i] = 16'($urandom);
      @(negedge clk);
      featmap_size = 5'd3;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int k = 0; k < 40 && seen < 10; k++) begin
         if (dout_en) seen++;
         if (seen < 10) @(negedge clk);
      end
      check("abort reached_10th_output", seen, 10);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs("abort");
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      run_frame(3, -1, 1'b0, 25, 9, 1'b1, 1'b0, -1, "after_abort");
   endtask

   typedef struct {
      int n;
      int mid_k;
      bit ramp;
      int exp_outs;
      int exp_reads;
      bit exp_acc;
   } vec_t;

   initial begin
      vec_t vecs[7];
      int   n, m;
      bit   acc;

      vecs[0] = '{n: 3,  mid_k: -1, ramp: 1'b1, exp_outs: 25,  exp_reads: 9,   exp_acc: 1'b1};
      vecs[1] = '{n: 28, mid_k: -1, ramp: 1'b0, exp_outs: 900, exp_reads: 784, exp_acc: 1'b1};
      vecs[2] = '{n: 3,  mid_k: 10, ramp: 1'b0, exp_outs: 25,  exp_reads: 9,   exp_acc: 1'b1};
      vecs[3] = '{n: 0,  mid_k: -1, ramp: 1'b0, exp_outs: 4,   exp_reads: 0,   exp_acc: 1'b1};
      vecs[4] = '{n: 30, mid_k: -1, ramp: 1'b0, exp_outs: 0,   exp_reads: 0,   exp_acc: 1'b0};
      vecs[5] = '{n: 1,  mid_k: -1, ramp: 1'b0, exp_outs: 9,   exp_reads: 1,   exp_acc: 1'b1};
      vecs[6] = '{n: 29, mid_k: -1, ramp: 1'b0, exp_outs: 961, exp_reads: 841, exp_acc: 1'b1};

      rst = 1'b0;
      start = 1'b0;
      featmap_size = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++)
         run_frame(vecs[i].n, vecs[i].mid_k, vecs[i].ramp, vecs[i].exp_outs, vecs[i].exp_reads,
                   vecs[i].exp_acc, 1'b0, -1, $sformatf("vec%0d_n%0d", i, vecs[i].n));

      reset_mid_frame();

      // Second start lands in the done cycle of the first frame.
      run_frame(4, -1, 1'b0, 36, 16, 1'b1, 1'b0, 3, "chain_first");
      run_frame(3, -1, 1'b0, 25, 9, 1'b1, 1'b1, -1, "chain_second");

      for (int j = 0; j < 4; j++) begin
         n   = int'($urandom_range(0, 31));
         m   = n + 2 * pad_p;
         acc = (m <= 31);
         run_frame(n, -1, 1'b0, acc ? m * m : 0, acc ? n * n : 0, acc, 1'b0, -1,
                   $sformatf("rand%0d_n%0d", j, n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
